// File: rtl/apb_master_unit.sv
// rtl/apb_master_unit.sv - APB requester with two decoded slave selects; optional ACCESS timeout under APB_MASTER_TIMEOUT_EN
module apb_master_unit #(
  parameter int ADDR_SEL_BIT   = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        TRANSFER,
  input  logic        READ_WRITE,
  input  logic [31:0] PADDR_IN,
  input  logic [31:0] PWDATA_IN,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic        PSLVERR,
  output logic        PSEL1,
  output logic        PSEL2,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        XFER_ERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t      state_q, state_d;
  // Remembers which slave owns the current transfer; PSELx alone is lost in IDLE.
  logic        sel2_q, sel2_d;
  logic        psel1_d, psel2_d, penable_d, pwrite_d, xfer_err_d;
  logic [31:0] paddr_d, pwdata_d, prdata_d;
  logic        active_ready;
  logic        accept;
  logic        go_idle;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  assign active_ready = sel2_q ? PREADY2 : PREADY1;

  // Next-state and next-output decode; every bus output is registered from here.
  always_comb begin
    state_d    = state_q;
    sel2_d     = sel2_q;
    psel1_d    = PSEL1;
    psel2_d    = PSEL2;
    penable_d  = PENABLE;
    pwrite_d   = PWRITE;
    paddr_d    = PADDR;
    pwdata_d   = PWDATA;
    prdata_d   = PRDATA;
    xfer_err_d = XFER_ERR;
    accept     = 1'b0;
    go_idle    = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (TRANSFER) begin
          accept     = 1'b1;
          xfer_err_d = 1'b0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (active_ready) begin
          xfer_err_d = PSLVERR;
          if (!PWRITE && !PSLVERR) begin
            prdata_d = sel2_q ? PRDATA2 : PRDATA1;
          end
          // Back-to-back: the completed transfer's status stays visible
          // while the next one runs.
          if (TRANSFER) begin
            accept = 1'b1;
          end else begin
            go_idle = 1'b1;
          end
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          xfer_err_d = 1'b1;
          go_idle    = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase

    if (go_idle) begin
      state_d   = IDLE;
      psel1_d   = 1'b0;
      psel2_d   = 1'b0;
      penable_d = 1'b0;
    end

    if (accept) begin
      state_d   = SETUP;
      sel2_d    = PADDR_IN[ADDR_SEL_BIT];
      psel1_d   = ~PADDR_IN[ADDR_SEL_BIT];
      psel2_d   = PADDR_IN[ADDR_SEL_BIT];
      penable_d = 1'b0;
      pwrite_d  = READ_WRITE;
      paddr_d   = PADDR_IN;
      pwdata_d  = PWDATA_IN;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_d = '0;
`endif
    end
  end

  // State and output registers; reset drops any transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      sel2_q    <= 1'b0;
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PRDATA    <= '0;
      XFER_ERR  <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel2_q    <= sel2_d;
      PSEL1     <= psel1_d;
      PSEL2     <= psel2_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      PRDATA    <= prdata_d;
      XFER_ERR  <= xfer_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_master_unit.sv
// tb/tb_apb_master_unit.sv - directed self-checking bench for apb_master_unit
module tb_apb_master_unit;

  logic        PCLK;
  logic        PRESETn;
  logic        TRANSFER;
  logic        READ_WRITE;
  logic [31:0] PADDR_IN;
  logic [31:0] PWDATA_IN;
  logic        PREADY1;
  logic        PREADY2;
  logic [31:0] PRDATA1;
  logic [31:0] PRDATA2;
  logic        PSLVERR;
  logic        PSEL1;
  logic        PSEL2;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        XFER_ERR;

  int checks = 0;
  int errors = 0;

  apb_master_unit dut (
    .PCLK       (PCLK),
    .PRESETn    (PRESETn),
    .TRANSFER   (TRANSFER),
    .READ_WRITE (READ_WRITE),
    .PADDR_IN   (PADDR_IN),
    .PWDATA_IN  (PWDATA_IN),
    .PREADY1    (PREADY1),
    .PREADY2    (PREADY2),
    .PRDATA1    (PRDATA1),
    .PRDATA2    (PRDATA2),
    .PSLVERR    (PSLVERR),
    .PSEL1      (PSEL1),
    .PSEL2      (PSEL2),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .XFER_ERR   (XFER_ERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Presents one request for a single edge (edge N), then drops TRANSFER.
  task automatic issue(input logic rw, input logic [31:0] addr, input logic [31:0] data);
    TRANSFER   = 1'b1;
    READ_WRITE = rw;
    PADDR_IN   = addr;
    PWDATA_IN  = data;
    step();
    TRANSFER   = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      TRANSFER   = i[0];
      READ_WRITE = 1'($urandom);
      PADDR_IN   = $urandom;
      PWDATA_IN  = $urandom;
      PREADY1    = 1'($urandom);
      PREADY2    = 1'($urandom);
      PRDATA1    = $urandom;
      PRDATA2    = $urandom;
      PSLVERR    = 1'($urandom);
      step();
      checks++;
      if ({PSEL1, PSEL2, PENABLE, PWRITE, XFER_ERR} !== 5'b0) begin
        errors++;
        $display("FAIL reset_ctrl cycle %0d got %b exp 00000", i, {PSEL1, PSEL2, PENABLE, PWRITE, XFER_ERR});
      end
      checks++;
      if ({PADDR, PWDATA, PRDATA} !== 96'b0) begin
        errors++;
        $display("FAIL reset_data cycle %0d got %h %h %h exp 0 0 0", i, PADDR, PWDATA, PRDATA);
      end
    end
    TRANSFER = 1'b0;
    PREADY1  = 1'b1;
    PREADY2  = 1'b1;
    PSLVERR  = 1'b0;
    PRDATA1  = 32'h0;
    PRDATA2  = 32'h0;
    PRESETn  = 1'b1;
    step();
    checks++;
    if ({PSEL1, PSEL2, PENABLE} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release got %b exp 000", {PSEL1, PSEL2, PENABLE});
    end
  endtask

  task automatic test_write_zero_wait();
    issue(1'b1, 32'd12, 32'd30);
    checks++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b0101 || PADDR !== 32'd12 || PWDATA !== 32'd30) begin
      errors++;
      $display("FAIL write_setup got sel1=%b sel2=%b en=%b wr=%b addr=%0d data=%0d exp 0 1 0 1 12 30",
               PSEL1, PSEL2, PENABLE, PWRITE, PADDR, PWDATA);
    end
    step();
    checks++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b0111) begin
      errors++;
      $display("FAIL write_access got %b exp 0111", {PSEL1, PSEL2, PENABLE, PWRITE});
    end
    step();
    checks++;
    if ({PSEL1, PSEL2, PENABLE, XFER_ERR} !== 4'b0000 || PADDR !== 32'd12) begin
      errors++;
      $display("FAIL write_done got ctrl=%b addr=%0d exp 0000 12", {PSEL1, PSEL2, PENABLE, XFER_ERR}, PADDR);
    end
  endtask

  task automatic test_read();
    PRDATA2 = 32'd30;
    PRDATA1 = 32'hDEAD_BEEF;
    issue(1'b0, 32'd12, 32'h0);
    checks++;
    if ({PSEL1, PSEL2, PWRITE} !== 3'b010) begin
      errors++;
      $display("FAIL read2_setup got %b exp 010", {PSEL1, PSEL2, PWRITE});
    end
    step();
    step();
    checks++;
    if (PRDATA !== 32'd30 || XFER_ERR !== 1'b0) begin
      errors++;
      $display("FAIL read2_data got %0d err=%b exp 30 0", PRDATA, XFER_ERR);
    end
    issue(1'b1, 32'd3, 32'd2);
    checks++;
    if ({PSEL1, PSEL2, PWRITE} !== 3'b101 || PADDR !== 32'd3 || PWDATA !== 32'd2) begin
      errors++;
      $display("FAIL write1_setup got %b addr=%0d data=%0d exp 101 3 2", {PSEL1, PSEL2, PWRITE}, PADDR, PWDATA);
    end
    step();
    step();
    checks++;
    if (PRDATA !== 32'd30) begin
      errors++;
      $display("FAIL write1_prdata got %0d exp 30", PRDATA);
    end
    PRDATA1 = 32'd2;
    PRDATA2 = 32'h5555_5555;
    issue(1'b0, 32'd3, 32'h0);
    checks++;
    if ({PSEL1, PSEL2, PWRITE} !== 3'b100) begin
      errors++;
      $display("FAIL read1_setup got %b exp 100", {PSEL1, PSEL2, PWRITE});
    end
    step();
    step();
    checks++;
    if (PRDATA !== 32'd2) begin
      errors++;
      $display("FAIL read1_data got %0d exp 2", PRDATA);
    end
  endtask

  task automatic test_wait_states();
    int en_cycles;
    en_cycles = 0;
    PREADY1 = 1'b0;
    issue(1'b1, 32'd5, 32'h77);
    step();
    for (int i = 0; i < 4; i++) begin
      if (PENABLE === 1'b1) en_cycles++;
      checks++;
      if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b1011 || PADDR !== 32'd5 || PWDATA !== 32'h77) begin
        errors++;
        $display("FAIL wait_hold cycle %0d got ctrl=%b addr=%0d data=%h exp 1011 5 77",
                 i, {PSEL1, PSEL2, PENABLE, PWRITE}, PADDR, PWDATA);
      end
      TRANSFER   = (i == 1);
      READ_WRITE = 1'b0;
      PADDR_IN   = 32'd12;
      PREADY1    = (i == 3);
      step();
      TRANSFER   = 1'b0;
    end
    checks++;
    if (en_cycles !== 4 || {PSEL1, PSEL2, PENABLE} !== 3'b000) begin
      errors++;
      $display("FAIL wait_done got en_cycles=%0d ctrl=%b exp 4 000", en_cycles, {PSEL1, PSEL2, PENABLE});
    end
    step();
    checks++;
    if ({PSEL1, PSEL2, PENABLE} !== 3'b000 || PADDR !== 32'd5) begin
      errors++;
      $display("FAIL wait_ignored got ctrl=%b addr=%0d exp 000 5", {PSEL1, PSEL2, PENABLE}, PADDR);
    end
  endtask

  task automatic test_slave_error();
    PRDATA1 = 32'h1234;
    PSLVERR = 1'b1;
    issue(1'b0, 32'd3, 32'h0);
    step();
    step();
    checks++;
    if (XFER_ERR !== 1'b1 || PRDATA !== 32'd2) begin
      errors++;
      $display("FAIL slverr_done got err=%b prdata=%0d exp 1 2", XFER_ERR, PRDATA);
    end
    PSLVERR = 1'b0;
    issue(1'b1, 32'd3, 32'd9);
    checks++;
    if (XFER_ERR !== 1'b0) begin
      errors++;
      $display("FAIL slverr_clear got %b exp 0", XFER_ERR);
    end
    step();
    step();
  endtask

  task automatic test_back_to_back();
    PREADY2 = 1'b1;
    PRDATA2 = 32'hA5;
    issue(1'b0, 32'd8, 32'h0);
    step();
    TRANSFER   = 1'b1;
    READ_WRITE = 1'b1;
    PADDR_IN   = 32'd0;
    PWDATA_IN  = 32'h99;
    step();
    TRANSFER   = 1'b0;
    checks++;
    if (PRDATA !== 32'hA5 || {PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b1001 || PADDR !== 32'd0 || PWDATA !== 32'h99) begin
      errors++;
      $display("FAIL b2b_setup got prdata=%h ctrl=%b addr=%0d data=%h exp a5 1001 0 99",
               PRDATA, {PSEL1, PSEL2, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    step();
    checks++;
    if ({PSEL1, PSEL2, PENABLE} !== 3'b101) begin
      errors++;
      $display("FAIL b2b_access got %b exp 101", {PSEL1, PSEL2, PENABLE});
    end
    step();
    checks++;
    if ({PSEL1, PSEL2, PENABLE, XFER_ERR} !== 4'b0000 || PRDATA !== 32'hA5) begin
      errors++;
      $display("FAIL b2b_done got ctrl=%b prdata=%h exp 0000 a5", {PSEL1, PSEL2, PENABLE, XFER_ERR}, PRDATA);
    end
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int  en_cycles;
    bit  done;
    en_cycles = 0;
    done      = 1'b0;
    PREADY1   = 1'b0;
    PRDATA1   = 32'hFFFF;
    issue(1'b0, 32'd0, 32'h0);
    for (int i = 0; i < 40 && !done; i++) begin
      if (PSEL1 !== 1'b1) done = 1'b1;
      else begin
        if (PENABLE === 1'b1) en_cycles++;
        step();
      end
    end
    checks++;
    if (!done || en_cycles !== 16 || XFER_ERR !== 1'b1 || PRDATA !== 32'hA5) begin
      errors++;
      $display("FAIL timeout got done=%b en_cycles=%0d err=%b prdata=%h exp 1 16 1 a5",
               done, en_cycles, XFER_ERR, PRDATA);
    end
  endtask
`endif

  task automatic test_reset_mid_access();
    PREADY1 = 1'b0;
    issue(1'b1, 32'd4, 32'hCAFE);
    step();
    step();
    checks++;
    if ({PSEL1, PENABLE} !== 2'b11) begin
      errors++;
      $display("FAIL midrst_pre got %b exp 11", {PSEL1, PENABLE});
    end
    #2;
    PRESETn = 1'b0;
    #1;
    checks++;
    if ({PSEL1, PSEL2, PENABLE, PWRITE, XFER_ERR} !== 5'b0 || {PADDR, PWDATA, PRDATA} !== 96'b0) begin
      errors++;
      $display("FAIL midrst_async got ctrl=%b addr=%h data=%h prdata=%h exp 0",
               {PSEL1, PSEL2, PENABLE, PWRITE, XFER_ERR}, PADDR, PWDATA, PRDATA);
    end
    step();
    PRESETn = 1'b1;
    PREADY1 = 1'b1;
    step();
    step();
    checks++;
    if ({PSEL1, PSEL2, PENABLE} !== 3'b000) begin
      errors++;
      $display("FAIL midrst_dropped got %b exp 000", {PSEL1, PSEL2, PENABLE});
    end
  endtask

  initial begin
    PRESETn    = 1'b0;
    TRANSFER   = 1'b0;
    READ_WRITE = 1'b0;
    PADDR_IN   = '0;
    PWDATA_IN  = '0;
    PREADY1    = 1'b1;
    PREADY2    = 1'b1;
    PRDATA1    = '0;
    PRDATA2    = '0;
    PSLVERR    = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read();
    test_wait_states();
    test_slave_error();
    test_back_to_back();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_unit.md
# apb_master_unit

APB requester that converts single-cycle transfer requests from local logic into APB read and write transactions. It drives one shared APB address, data and control bus, plus two slave-select lines, and decodes the target slave from one address bit. It sits between a requester and two APB peripherals. It returns read data and error status to the requester.

## Interface
- ADDR_SEL_BIT, default 3: PADDR_IN bit that selects the slave (0 selects slave 1, 1 selects slave 2).
- TIMEOUT_CYCLES, default 16: maximum number of ACCESS cycles waiting for PREADY. Used only when APB_MASTER_TIMEOUT_EN is defined.
- PCLK  in  1  clock; all logic updates on the rising edge.
- PRESETn  in  1  reset; asynchronous, active-low.
- TRANSFER  in  1  request strobe, sampled at the rising edge.
- READ_WRITE  in  1  request direction: 1 = write, 0 = read.
- PADDR_IN  in  32  request address.
- PWDATA_IN  in  32  request write data.
- PREADY1  in  1  ready from slave 1.
- PREADY2  in  1  ready from slave 2.
- PRDATA1  in  32  read data from slave 1.
- PRDATA2  in  32  read data from slave 2.
- PSLVERR  in  1  shared slave error.
- PSEL1  out  1  select for slave 1.
- PSEL2  out  1  select for slave 2.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PRDATA  out  32  last successful read data, registered.
- XFER_ERR  out  1  error status of the last transfer, registered.

## Operation
- State machine with three states: IDLE, SETUP, ACCESS.
- IDLE: PSEL1, PSEL2 and PENABLE are 0.
  - TRANSFER=1 at an edge: capture PADDR_IN→PADDR, PWDATA_IN→PWDATA, READ_WRITE→PWRITE and the decoded select; clear XFER_ERR; go to SETUP.
- SETUP: the decoded PSELx=1, PENABLE=0. Unconditionally go to ACCESS.
- ACCESS: PSELx=1, PENABLE=1. The active ready is PREADY1 or PREADY2, according to the select.
  - Active ready = 0: stay in ACCESS. All APB outputs are held stable.
  - Active ready = 1: the transfer completes.
    - XFER_ERR ← PSLVERR.
    - If the transfer is a read and PSLVERR=0: PRDATA ← PRDATA1 or PRDATA2, according to the select.
    - If TRANSFER=1 at the same edge: capture the new request and go to SETUP (back-to-back transfer).
    - Otherwise go to IDLE.
- TRANSFER is ignored in SETUP and in ACCESS wait cycles. Requests are not queued.
- PSEL1 and PSEL2 are never 1 at the same time.
- The unselected slave's PREADY and PRDATA are ignored.
- PSLVERR is ignored except at the completing ACCESS edge.
- PADDR, PWDATA and PWRITE keep their last values in IDLE.
- PRDATA is unchanged by writes and by reads that return an error.

## Timing
- All outputs are registered.
- Reset values: state IDLE; PSEL1, PSEL2, PENABLE, PWRITE and XFER_ERR = 0; PADDR, PWDATA and PRDATA = 0.
- Assertion of PRESETn=0 at any time, including mid-transfer, forces the reset values immediately. Any pending transfer is dropped.
- TRANSFER sampled at edge N:
  - PSELx=1 and the bus values are valid after edge N.
  - PENABLE=1 after edge N+1.
  - With a zero-wait slave, the transfer completes at edge N+2. PRDATA and XFER_ERR update after edge N+2.
- Each wait cycle (active ready=0) extends ACCESS by exactly one cycle.
- Back-to-back transfers: after edge N+2, SETUP for the next transfer occurs with no idle cycle in between.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A counter counts ACCESS cycles.
  - If TIMEOUT_CYCLES ACCESS cycles elapse without the active ready, the FSM aborts to IDLE, sets XFER_ERR=1 and leaves PRDATA unchanged.
  - The counter clears on entry to SETUP.
- APB_MASTER_TIMEOUT_EN undefined: no counter is built and the master waits indefinitely for PREADY.

## Test plan
- Reset: hold PRESETn=0 with random inputs → all outputs 0; TRANSFER pulses have no effect.
- Write 30 to address 12 with a zero-wait slave → PSEL2=1, PSEL1=0, PADDR=12, PWDATA=30, PWRITE=1.
  - Required sequence: SETUP for 1 cycle, ACCESS for 1 cycle, then IDLE, with XFER_ERR=0.
- Read address 12 with PRDATA2=30 → PSEL2 transaction with PWRITE=0; PRDATA=30 after completion. Then write 2 to address 3 and read it back with PRDATA1=2 → PSEL1 used; PRDATA=2.
- Hold PREADY1=0 for 3 ACCESS cycles → PENABLE=1 for 4 cycles; PADDR, PWDATA and PWRITE stable throughout. A TRANSFER pulse during the wait is ignored.
- Read with PSLVERR=1 at completion → XFER_ERR=1 and PRDATA unchanged. XFER_ERR clears on the next accepted TRANSFER.
- With APB_MASTER_TIMEOUT_EN defined and PREADY held 0 → return to IDLE after 16 ACCESS cycles with XFER_ERR=1. Also drive PRESETn low mid-ACCESS → outputs reset immediately.
